// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter with a rotating priority pointer.
// Latency: one cycle from req sampled to gnt visible; handover on release takes one edge, no idle gap.
// Backpressure: the owner keeps the grant until done or a request drop; optional forced revoke under RR_ARB_TIMEOUT_EN.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Elaboration-time guard on the hold limit (the counter is 8 bits wide).
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter8: MAX_HOLD must be in 1..255");
  end

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] gnt_id_q, gnt_id_d;
  logic       gnt_valid_q, gnt_valid_d;
  logic       timeout_q, timeout_d;

  logic [7:0] cand;
  logic       win_found;
  logic [2:0] win_id;
  logic       owner_req;
  logic       to_hit;
  logic       release_ev;

`ifdef RR_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_q, hold_d;
`endif

  // Pick the first candidate in search order ptr, ptr+1, ..., ptr+7; the current owner is excluded on handover.
  always_comb begin
    logic [2:0] idx;
    idx       = ptr_q;
    cand      = (state_q == GRANT) ? (req & ~gnt_q) : req;
    win_found = 1'b0;
    win_id    = ptr_q;
    for (int i = 7; i >= 0; i--) begin
      idx = ptr_q + 3'(i);
      if (cand[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  // Release detection: done, owner dropping its request, or the hold limit being reached.
  always_comb begin
    owner_req = req[gnt_id_q];
`ifdef RR_ARB_TIMEOUT_EN
    to_hit = (state_q == GRANT) && (hold_q == HOLD_LAST);
`else
    to_hit = 1'b0;
`endif
    release_ev = done | ~owner_req | to_hit;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
    hold_d      = hold_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d     = GRANT;
          ptr_d       = win_id + 3'd1;
          gnt_d       = 8'd1 << win_id;
          gnt_id_d    = win_id;
          gnt_valid_d = 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
          hold_d      = 8'd0;
`endif
        end
      end
      GRANT: begin
        if (release_ev) begin
          // Pulse only when the revoke is forced, not when the owner released anyway.
          timeout_d = to_hit & ~done & owner_req;
          if (win_found) begin
            ptr_d       = win_id + 3'd1;
            gnt_d       = 8'd1 << win_id;
            gnt_id_d    = win_id;
            gnt_valid_d = 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
            hold_d      = 8'd0;
`endif
          end else begin
            state_d     = IDLE;
            gnt_d       = 8'd0;
            gnt_id_d    = 3'd0;
            gnt_valid_d = 1'b0;
          end
        end else begin
`ifdef RR_ARB_TIMEOUT_EN
          hold_d = hold_q + 8'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 3'd0;
      gnt_q       <= 8'd0;
      gnt_id_q    <= 3'd0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      hold_q      <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
`ifdef RR_ARB_TIMEOUT_EN
      hold_q      <= hold_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed scenarios with literal expectations, then a long random run
// checked every cycle against a behavioural round-robin model (owner index + priority pointer).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_rr_arbiter8;

  localparam int MH = 4;
`ifdef RR_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int n_cmp;
  int n_bad;

  rr_arbiter8 #(.MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  int m_owner;        // -1 when nobody holds the grant
  int m_ptr;
  int m_hold;
  bit m_to;
  bit started;
  int wait_cnt [8];

  function automatic int rr_pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic note_grant(input int w, input logic [7:0] r);
    chk("fairness_wait", (wait_cnt[w] <= 8) ? 1 : 0, 1);
    for (int i = 0; i < 8; i++) begin
      if (i == w || !r[i]) wait_cnt[i] = 0;
      else wait_cnt[i]++;
    end
  endtask

  always @(posedge clk) begin
    logic [7:0] r;
    int w;
    bit tohit;
    r = req;
    started = 1'b1;
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_hold  = 0;
      m_to    = 1'b0;
      for (int i = 0; i < 8; i++) wait_cnt[i] = 0;
    end else begin
      m_to = 1'b0;
      for (int i = 0; i < 8; i++) if (!r[i]) wait_cnt[i] = 0;
      if (m_owner < 0) begin
        w = rr_pick(r, m_ptr);
        if (w >= 0) begin
          note_grant(w, r);
          m_owner = w;
          m_ptr   = (w + 1) % 8;
          m_hold  = 0;
        end
      end else begin
        tohit = TO_EN && (m_hold == MH - 1);
        if (done || !r[m_owner] || tohit) begin
          m_to = tohit && !done && r[m_owner];
          w = rr_pick(r & ~(8'd1 << m_owner), m_ptr);
          if (w >= 0) begin
            note_grant(w, r);
            m_owner = w;
            m_ptr   = (w + 1) % 8;
            m_hold  = 0;
          end else begin
            m_owner = -1;
          end
        end else begin
          m_hold++;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    int ex_gnt;
    int ex_id;
    int enc;
    if (started) begin
      ex_gnt = (m_owner >= 0) ? (1 << m_owner) : 0;
      ex_id  = (m_owner >= 0) ? m_owner : 0;
      chk("gnt", int'(gnt), ex_gnt);
      chk("gnt_id", int'(gnt_id), ex_id);
      chk("gnt_valid", int'(gnt_valid), (m_owner >= 0) ? 1 : 0);
      chk("timeout", int'(timeout), int'(m_to));
      chk("onehot0", int'($onehot0(gnt)), 1);
      enc = 0;
      for (int i = 0; i < 8; i++) if (gnt[i]) enc = i;
      chk("gnt_id_enc", int'(gnt_id), enc);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 8'h00; done = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; started = 1'b0;
    m_owner = -1; m_ptr = 0; m_hold = 0; m_to = 1'b0;
    for (int i = 0; i < 8; i++) wait_cnt[i] = 0;
    rst = 1'b1; req = 8'h00; done = 1'b0;
    tick(); tick();
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_valid", int'(gnt_valid), 0);
    chk("rst_id", int'(gnt_id), 0);
    chk("rst_to", int'(timeout), 0);
    rst = 1'b0;

    // Two requesters, done hands over with no gap.
    req = 8'b0000_0101;
    tick();
    chk("d026_gnt", int'(gnt), 8'h01);
    chk("d026_id", int'(gnt_id), 0);
    chk("d026_model", m_owner, 0);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("d026_hand_gnt", int'(gnt), 8'h04);
    chk("d026_hand_id", int'(gnt_id), 2);
    chk("d026_hand_valid", int'(gnt_valid), 1);
    req = 8'h00;
    tick(); tick();

    // All requesting, done every cycle: rotation 0..7 then wrap.
    do_reset();
    req = 8'hFF;
    tick();
    chk("d027_first", int'(gnt_id), 0);
    done = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("d027_seq", int'(gnt_id), k % 8);
      chk("d027_model", m_owner, k % 8);
    end
    done = 1'b0; req = 8'h00;
    tick(); tick();

    // Lone owner releasing with done: one idle cycle, then re-granted.
    do_reset();
    req = 8'h08;
    tick();
    chk("d028_id", int'(gnt_id), 3);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("d028_idle", int'(gnt_valid), 0);
    tick();
    chk("d028_regrant_id", int'(gnt_id), 3);
    chk("d028_regrant_valid", int'(gnt_valid), 1);
    req = 8'h00;
    tick();

    // Reset mid-grant drops the grant; next grant favours requester 0.
    do_reset();
    req = 8'h20;
    tick();
    chk("d029_id5", int'(gnt_id), 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("d029_rst_gnt", int'(gnt), 0);
    chk("d029_rst_valid", int'(gnt_valid), 0);
    req = 8'b0010_0001;
    tick();
    chk("d029_after_id", int'(gnt_id), 0);
    req = 8'h00;
    tick();

`ifdef RR_ARB_TIMEOUT_EN
    // Forced revoke after MH cycles of holding.
    do_reset();
    req = 8'b0000_0011;
    tick();
    chk("d030_id0", int'(gnt_id), 0);
    for (int c = 1; c < MH; c++) begin
      tick();
      chk("d030_hold", int'(gnt_id), 0);
      chk("d030_no_to", int'(timeout), 0);
    end
    tick();
    chk("d030_to", int'(timeout), 1);
    chk("d030_next", int'(gnt_id), 1);
    tick();
    chk("d030_to_pulse", int'(timeout), 0);
    req = 8'h00;
    tick();
`endif

    // Random traffic: requests flip rarely so many stay asserted for a while.
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      logic [7:0] nr;
      nr = req;
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 7) == 0) nr[b] = ~nr[b];
      req  = nr;
      done = ($urandom_range(0, 3) == 0);
      rst  = ($urandom_range(0, 1999) == 0);
      tick();
    end
    rst = 1'b0; req = 8'h00; done = 1'b0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 Parameter MAX_HOLD, default 15, maximum grant duration in cycles when the timeout is compiled in (legal range 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  8  request vector; bit i = requester i wants the shared resource.
REQ-005 done  input  1  current owner releases the grant; ignored while gnt_valid=0.
REQ-006 gnt  output  8  one-hot grant vector; all zero when no owner.
REQ-007 gnt_id  output  3  binary index of the granted requester; 0 when gnt_valid=0.
REQ-008 gnt_valid  output  1  high while any grant is held.
REQ-009 timeout  output  1  one-cycle pulse when a grant is forcibly revoked; constant 0 without the macro.

Function
REQ-010 Two-state FSM: IDLE (no owner), GRANT (one owner); all outputs registered.
REQ-011 Priority pointer ptr[2:0] names the highest-priority requester; search order is ptr, ptr+1, ..., ptr+7, modulo 8.
REQ-012 IDLE: if req != 0 -> GRANT, winner = first set bit in search order; gnt/gnt_id/gnt_valid update on that edge (latency one cycle from req sampled to gnt visible).
REQ-013 IDLE with req == 0: remain IDLE, outputs stay zero.
REQ-014 On every new grant: ptr <= winner+1 (wraps 7 -> 0), so the winner becomes lowest priority.
REQ-015 GRANT: owner holds the grant while req[gnt_id]=1 and done=0; other requests do not preempt.
REQ-016 Release event = done=1 OR req[gnt_id]=0 (owner drops request) OR timeout (REQ-024).
REQ-017 On release with req & ~gnt != 0: direct handover, next owner chosen per REQ-011 with the updated ptr, gnt changes in one edge with no idle cycle.
REQ-018 On release with no other requester: -> IDLE, outputs zero next cycle; owner still requesting with done=1 is re-eligible only from IDLE (one idle cycle).
REQ-019 gnt always one-hot or zero; gnt_id always equals the encoded gnt.
REQ-020 Simultaneous done and new req bits in the same cycle: new bits participate in the handover search.

Reset
REQ-021 rst sampled high: state <= IDLE, ptr <= 0, gnt <= 0, gnt_id <= 0, gnt_valid <= 0, timeout <= 0, hold counter <= 0.
REQ-022 rst asserted mid-grant: grant dropped on the same edge; first grant after reset favours requester 0.
REQ-023 rst has priority over all other inputs.

Configuration
REQ-024 Macro RR_ARB_TIMEOUT_EN defined: 8-bit hold counter clears on each new grant, increments per GRANT cycle; when count reaches MAX_HOLD-1 without another release event, the grant is revoked on the next edge, timeout pulses high for exactly one cycle, handover per REQ-017/018.
REQ-025 Macro undefined: no hold counter; grants held until done or request drop; timeout tied to 0.

Verification
REQ-026 req=8'b00000101 after reset, hold -> gnt=00000001, gnt_id=0 one cycle later; done pulse -> gnt=00000100, gnt_id=2 next cycle, no gap.
REQ-027 req=8'hFF held, done pulsed every grant -> gnt_id sequence 0,1,2,...,7,0 (fairness and wrap-around).
REQ-028 Owner 3 alone, done=1 while req[3] still 1 -> one IDLE cycle (gnt_valid=0), then gnt_id=3 again.
REQ-029 gnt_id=5 held, rst pulsed one cycle -> gnt=0 after edge; req=8'b00100001 then -> gnt_id=0.
REQ-030 RR_ARB_TIMEOUT_EN defined, MAX_HOLD=4, req=8'b00000011, no done -> owner 0 held 4 cycles, timeout pulse, gnt_id=1 on the revoking edge.
REQ-031 Random req/done for 10000 cycles -> gnt never multi-hot, gnt_id matches gnt, every continuously asserted request granted within 8 grant periods.
